// File: rtl/wb_stage.sv
// wb_stage: writeback stage sitting directly behind the execute ALU.
//
// Accepts {opcode, rd, result} from execute through a valid/ready handshake.
// Results sit in a 2-entry skid buffer and then commit, in order, to the
// register-file write port. The head entry is also driven onto a forwarding
// bus for the operand stage.
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   in_valid / in_ready          execute handshake (in_ready is registered)
//   in_op, in_rd, in_result      opcode, destination index, ALU output
//   wb_hold                      write port unavailable; head does not retire
//   rf_we, rf_waddr, rf_wdata    registered register-file write port
//   fwd_valid, fwd_rd, fwd_data  head-entry bypass (combinational from buffer)
//   ill_op                       one-cycle pulse when an undefined opcode retires
//   flag_z, flag_n               (WB_FLAGS_EN only) zero/negative of last write
//
// Optional feature macro: WB_FLAGS_EN adds the flag_z/flag_n outputs.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef WORD
`define WORD [`WORD_SIZE-1:0]
`endif
`ifndef OPCODE
`define OPCODE [3:0]
`endif

module wb_stage #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic `OPCODE      in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic `WORD        in_result,
  input  logic              wb_hold,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic `WORD        rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic `WORD        fwd_data,
  output logic              ill_op
`ifdef WB_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  localparam logic `OPCODE OP_NOP         = 4'd0;
  localparam logic `OPCODE OP_MOV_REG_REG = 4'd1;
  localparam logic `OPCODE OP_ADD_REG     = 4'd2;
  localparam logic `OPCODE OP_SUB_REG     = 4'd3;
  localparam logic `OPCODE OP_MUL_REG     = 4'd4;
  localparam logic `OPCODE OP_AND_REG     = 4'd5;
  localparam logic `OPCODE OP_ORR_REG     = 4'd6;
  localparam logic `OPCODE OP_XOR_REG     = 4'd7;

  function automatic logic op_writes(input logic `OPCODE op);
    return op inside {OP_MOV_REG_REG, OP_ADD_REG, OP_SUB_REG, OP_MUL_REG,
                      OP_AND_REG, OP_ORR_REG, OP_XOR_REG};
  endfunction

  // Buffer storage; index 0 is always the head (oldest) entry.
  logic `OPCODE      r_op   [2];
  logic [REG_AW-1:0] r_rd   [2];
  logic `WORD        r_data [2];
  logic [1:0]        r_count;
  logic              r_in_ready;

  logic              r_rf_we;
  logic [REG_AW-1:0] r_rf_waddr;
  logic `WORD        r_rf_wdata;
  logic              r_ill_op;

  logic              w_commit;
  logic              w_accept;
  logic [1:0]        w_cnt_pop;
  logic [1:0]        w_cnt_n;
  logic              w_head_writes;
  logic              w_head_ill;
  logic              w_we_n;
  logic `OPCODE      w_op_n   [2];
  logic [REG_AW-1:0] w_rd_n   [2];
  logic `WORD        w_data_n [2];

  assign w_commit = (r_count != 2'd0) && !wb_hold;
  // r_in_ready already encodes count < DEPTH, so no count test is needed here.
  assign w_accept = in_valid && r_in_ready;

  assign w_cnt_pop = r_count - {1'b0, w_commit};
  assign w_cnt_n   = w_cnt_pop + {1'b0, w_accept};

  // $isunknown folds to 0 in synthesis; it only matters for X results in simulation.
  assign w_head_writes = op_writes(r_op[0]) && (r_rd[0] != '0) && !$isunknown(r_data[0]);
  assign w_head_ill    = !op_writes(r_op[0]) && (r_op[0] != OP_NOP);
  assign w_we_n        = w_commit && w_head_writes;

  // Next buffer contents: shift the head out on commit, then append the accepted
  // entry behind whatever remains.
  always_comb begin
    w_op_n   = r_op;
    w_rd_n   = r_rd;
    w_data_n = r_data;
    if (w_commit) begin
      w_op_n[0]   = r_op[1];
      w_rd_n[0]   = r_rd[1];
      w_data_n[0] = r_data[1];
    end
    if (w_accept) begin
      // An accept implies at most one entry survives the pop, so bit 0 indexes.
      w_op_n[w_cnt_pop[0]]   = in_op;
      w_rd_n[w_cnt_pop[0]]   = in_rd;
      w_data_n[w_cnt_pop[0]] = in_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= '{default: '0};
      r_rd       <= '{default: '0};
      r_data     <= '{default: '0};
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_ill_op   <= 1'b0;
    end else begin
      r_op       <= w_op_n;
      r_rd       <= w_rd_n;
      r_data     <= w_data_n;
      r_count    <= w_cnt_n;
      r_in_ready <= {30'd0, w_cnt_n} < DEPTH;
      r_rf_we    <= w_we_n;
      r_ill_op   <= w_commit && w_head_ill;
      // Address/data only move on a real write so X results never leak out.
      if (w_we_n) begin
        r_rf_waddr <= r_rd[0];
        r_rf_wdata <= r_data[0];
      end
    end
  end

`ifdef WB_FLAGS_EN
  logic r_flag_z;
  logic r_flag_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else if (w_we_n) begin
      r_flag_z <= (r_data[0] == '0);
      r_flag_n <= r_data[0][`WORD_SIZE-1];
    end
  end

  assign flag_z = r_flag_z;
  assign flag_n = r_flag_n;
`endif

  assign in_ready  = r_in_ready;
  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;
  assign ill_op    = r_ill_op;
  assign fwd_valid = (r_count != 2'd0) && w_head_writes;
  assign fwd_rd    = r_rd[0];
  assign fwd_data  = r_data[0];

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage.
// A fixed vector table covers the directed scenarios; a queue-based model of the
// skid buffer checks every cycle, including a randomized run with occasional resets.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef WORD
`define WORD [`WORD_SIZE-1:0]
`endif
`ifndef OPCODE
`define OPCODE [3:0]
`endif

module tb_wb_stage;

  localparam int unsigned AW = 5;

  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] MOV   = 4'd1;
  localparam logic [3:0] ADD   = 4'd2;
  localparam logic [3:0] SUB   = 4'd3;
  localparam logic [3:0] XOR   = 4'd7;
  localparam logic [3:0] UNDEF = 4'hC;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [31:0]   in_result;
  logic          wb_hold;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [31:0]   rf_wdata;
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [31:0]   fwd_data;
  logic          ill_op;
`ifdef WB_FLAGS_EN
  logic          flag_z;
  logic          flag_n;
`endif

  always #5 clk = ~clk;

  wb_stage #(.REG_AW(AW), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_result (in_result),
    .wb_hold   (wb_hold),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .ill_op    (ill_op)
`ifdef WB_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_n    (flag_n)
`endif
  );

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [31:0]   data;
  } ent_t;

  typedef struct {
    logic          v;
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [31:0]   data;
    logic          hold;
    logic          exp_we;
    logic [AW-1:0] exp_waddr;
    logic [31:0]   exp_wdata;
    logic          exp_ill;
    logic          exp_ready;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model state: pending entries in acceptance order plus the
  // expected registered outputs.
  ent_t          mq[$];
  logic          m_we;
  logic          m_ill;
  logic [AW-1:0] m_waddr;
  logic [31:0]   m_wdata;
  logic          m_fz;
  logic          m_fn;

  function automatic logic writes_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd7);
  endfunction

  function automatic logic qual(input ent_t e);
    return writes_op(e.op) && (e.rd != '0) && !$isunknown(e.data);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic fv;
    fv = (mq.size() > 0) ? qual(mq[0]) : 1'b0;
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("ill_op", {31'd0, ill_op}, {31'd0, m_ill});
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, fv});
    if (fv) begin
      chk("fwd_rd", {27'd0, fwd_rd}, {27'd0, mq[0].rd});
      chk("fwd_data", fwd_data, mq[0].data);
    end
    if (m_we) begin
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
      chk("rf_wdata", rf_wdata, m_wdata);
    end
`ifdef WB_FLAGS_EN
    chk("flag_z", {31'd0, flag_z}, {31'd0, m_fz});
    chk("flag_n", {31'd0, flag_n}, {31'd0, m_fn});
`endif
  endtask

  // Drive one cycle, advance the model across the edge, and compare after it.
  task automatic step(input logic v, input logic [3:0] op, input logic [AW-1:0] rd,
                      input logic [31:0] d, input logic h);
    int   n;
    logic com;
    logic acc;
    ent_t e;
    in_valid  = v;
    in_op     = op;
    in_rd     = rd;
    in_result = d;
    wb_hold   = h;
    n   = mq.size();
    com = (n > 0) && !h;
    acc = v && (n < 2);
    m_we  = 1'b0;
    m_ill = 1'b0;
    if (com) begin
      e     = mq.pop_front();
      m_we  = qual(e);
      m_ill = !writes_op(e.op) && (e.op != NOP);
      if (m_we) begin
        m_waddr = e.rd;
        m_wdata = e.data;
        m_fz    = (e.data == 32'd0);
        m_fn    = e.data[31];
      end
    end
    if (acc) mq.push_back('{op: op, rd: rd, data: d});
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_we    = 1'b0;
    m_ill   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_fz    = 1'b0;
    m_fn    = 1'b0;
    check_outputs();
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_fwd_rd", {27'd0, fwd_rd}, 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
  endtask

  vec_t tbl[15];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_rd     = '0;
    in_result = '0;
    wb_hold   = 1'b0;

    // Expectations describe outputs just after the edge that ends each cycle.
    tbl[0]  = '{1'b1, ADD,   5'd3, 32'd7,  1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b1};
    tbl[1]  = '{1'b0, NOP,   5'd0, 32'd0,  1'b0, 1'b1, 5'd3, 32'd7,  1'b0, 1'b1};
    tbl[2]  = '{1'b0, NOP,   5'd0, 32'd0,  1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b1};
    tbl[3]  = '{1'b1, MOV,   5'd1, 32'd11, 1'b1, 1'b0, 5'd0, 32'd0,  1'b0, 1'b1};
    tbl[4]  = '{1'b1, MOV,   5'd2, 32'd22, 1'b1, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0};
    tbl[5]  = '{1'b1, MOV,   5'd3, 32'd33, 1'b1, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0};
    tbl[6]  = '{1'b1, MOV,   5'd3, 32'd33, 1'b0, 1'b1, 5'd1, 32'd11, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, MOV,   5'd3, 32'd33, 1'b0, 1'b1, 5'd2, 32'd22, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, NOP,   5'd0, 32'd0,  1'b0, 1'b1, 5'd3, 32'd33, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, NOP,   5'd5, 32'd55, 1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b1};
    tbl[10] = '{1'b1, MOV,   5'd0, 32'd99, 1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b1};
    tbl[11] = '{1'b0, NOP,   5'd0, 32'd0,  1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b1};
    tbl[12] = '{1'b1, UNDEF, 5'd4, 32'hx,  1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b1};
    tbl[13] = '{1'b0, NOP,   5'd0, 32'd0,  1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b1};
    tbl[14] = '{1'b0, NOP,   5'd0, 32'd0,  1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b1};

    @(posedge clk);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].data, tbl[i].hold);
      chk($sformatf("tbl%0d_we", i), {31'd0, rf_we}, {31'd0, tbl[i].exp_we});
      chk($sformatf("tbl%0d_ill", i), {31'd0, ill_op}, {31'd0, tbl[i].exp_ill});
      chk($sformatf("tbl%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_ready});
      if (tbl[i].exp_we) begin
        chk($sformatf("tbl%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, tbl[i].exp_waddr});
        chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].exp_wdata);
      end
    end

    // Reset with two entries parked under hold: nothing may retire afterwards.
    step(1'b1, ADD, 5'd6, 32'h66, 1'b1);
    step(1'b1, ADD, 5'd7, 32'h77, 1'b1);
    chk("hold_full_ready", {31'd0, in_ready}, 32'd0);
    chk("hold_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    do_reset();
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_fwd", {31'd0, fwd_valid}, 32'd0);
    step(1'b0, NOP, 5'd0, 32'd0, 1'b0);
    chk("post_rst_no_we", {31'd0, rf_we}, 32'd0);
    step(1'b0, NOP, 5'd0, 32'd0, 1'b0);
    chk("post_rst_no_we2", {31'd0, rf_we}, 32'd0);

    // Flag sequence: zero result, negative result, then a NOP that must not touch flags.
    step(1'b1, SUB, 5'd1, 32'd0, 1'b0);
    step(1'b1, XOR, 5'd2, 32'h8000_0000, 1'b0);
    chk("sub_we", {31'd0, rf_we}, 32'd1);
`ifdef WB_FLAGS_EN
    chk("sub_flag_z", {31'd0, flag_z}, 32'd1);
    chk("sub_flag_n", {31'd0, flag_n}, 32'd0);
`endif
    step(1'b1, NOP, 5'd5, 32'd0, 1'b0);
    chk("xor_wdata", rf_wdata, 32'h8000_0000);
`ifdef WB_FLAGS_EN
    chk("xor_flag_z", {31'd0, flag_z}, 32'd0);
    chk("xor_flag_n", {31'd0, flag_n}, 32'd1);
`endif
    step(1'b0, NOP, 5'd0, 32'd0, 1'b0);
    chk("nop_we", {31'd0, rf_we}, 32'd0);
`ifdef WB_FLAGS_EN
    chk("nop_flag_z", {31'd0, flag_z}, 32'd0);
    chk("nop_flag_n", {31'd0, flag_n}, 32'd1);
`endif

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      logic [3:0]  op;
      logic [31:0] d;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                         : 4'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0:       d = 32'd0;
          1:       d = 32'h8000_0000 | $urandom;
          default: d = $urandom;
        endcase
        step(1'($urandom_range(0, 1)), op, 5'($urandom_range(0, 31)), d,
             ($urandom_range(0, 9) < 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of the execute ALU.
- Captures the ALU result together with the destination register and opcode, buffers it through a 2-entry skid, and commits it to the register-file write port.
- Provides a forwarding bus to the operand stage.
- Flags opcodes the ALU does not define, and drops their writes.

Parameters:
- REG_AW, 5, register-file address width (32 GPRs).
- DEPTH, 2, skid-buffer entries; fixed at 2, other values are unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents a result.
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready at a clk edge.
- in_op  in  `OPCODE  opcode that produced the result.
- in_rd  in  REG_AW  destination register index.
- in_result  in  `WORD  ALU output y.
- wb_hold  in  1  writeback port unavailable this cycle; no commit while high.
- rf_we  out  1  register-file write strobe, one cycle per commit.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  `WORD  write data.
- fwd_valid  out  1  head entry valid and writing; bypass allowed.
- fwd_rd  out  REG_AW  head entry destination.
- fwd_data  out  `WORD  head entry data.
- ill_op  out  1  one-cycle pulse when a committed entry has an undefined opcode.

Behaviour:
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0, ill_op=0, fwd_valid=0, fwd_rd=0, fwd_data=0.
  - Buffer count=0; in_ready=1 on the first cycle after reset.
- Buffer states, keyed on entry count:
  - EMPTY (0): in_ready=1.
  - ONE (1): in_ready=1.
  - FULL (2): in_ready=0.
  - in_ready is a registered output derived from the next-state count, with no combinational path from wb_hold.
- Commit condition: count>0 && !wb_hold. The head entry retires at the clk edge.
  - rf_we/rf_waddr/rf_wdata are registered and valid the following cycle.
  - Latency from accept into EMPTY to rf_we=1 is 2 cycles when wb_hold=0.
- Write qualification: a retiring entry sets rf_we=1 only if all of the following hold:
  - op is one of MOV_REG_REG, ADD_REG, SUB_REG, MUL_REG, AND_REG, ORR_REG, XOR_REG;
  - rd != 0;
  - result has no X/Z bits.
- Per-opcode handling:
  - NOP retires silently: rf_we=0, ill_op=0.
  - Any other opcode retires with rf_we=0 and ill_op=1 for one cycle.
- Simultaneous accept and commit:
  - In ONE, the count stays 1 and the new entry becomes head.
  - In FULL, no accept is possible; commit moves the count to 1, and in_ready returns to 1 the next cycle.
- Forwarding:
  - fwd_* reflects the head entry combinationally from buffer registers, never from in_*.
  - fwd_valid=1 only when count>0 and the head qualifies for a write.
- Ordering: entries commit strictly in acceptance order, with no reordering or coalescing.
- Hold: wb_hold=1 freezes the head. rf_we=0 on every cycle after a held edge, and the buffer still accepts up to FULL.
- Reset mid-operation:
  - Buffered entries are discarded, with no rf_we.
  - All outputs return to their reset values on the next edge.
  - in_ready=1 follows.

Optional Feature:
- Macro: WB_FLAGS_EN.
- When defined:
  - Adds outputs flag_z (1) and flag_n (1), registered and reset to 0.
  - Updated only on a qualifying write (rf_we=1): flag_z=(wdata==0), flag_n=wdata[`WORD_SIZE-1].
  - Unchanged otherwise.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then a single accept of ADD_REG, rd=3, result=32'h0000_0007 with wb_hold=0 -> rf_we=1, waddr=3, wdata=7 exactly 2 cycles after accept; in_ready stays 1.
- wb_hold=1 with three consecutive valid offers (rd=1,2,3) -> entries 1 and 2 accepted, in_ready=0 from the third cycle. Release hold -> commits in order 1, 2, then 3 is accepted, and in_ready returns to 1.
- NOP with rd=5, and MOV_REG_REG with rd=0 -> rf_we stays 0 for both; ill_op stays 0.
- Undefined opcode with result=32'hx, rd=4 -> rf_we=0, and ill_op pulses high for exactly 1 cycle at retire.
- Two entries buffered under hold, then rst=1 for one cycle -> no rf_we afterward, fwd_valid=0, in_ready=1 the cycle after reset deasserts.
- With WB_FLAGS_EN: SUB_REG result 0 -> flag_z=1, flag_n=0; then XOR_REG result 32'h8000_0000 -> flag_z=0, flag_n=1; then NOP -> flags unchanged.
